mdom_wvb_capture: RTL and testbench

Waveform capture controller that consumes the registered ADC/discriminator stream and the `trig`/`trig_src` pulse produced by the mDOM trigger block. On an accepted trigger it writes one event into the waveform buffer: a programmable number of pre-trigger samples, the trigger sample, and post-trigger samples. It then emits one header word carrying the trigger source, timestamp and length. It sits between `mdom_trigger` and the waveform buffer FIFO/RAM.

---
 rtl/mdom_wvb_capture_pkg.sv | 58 +++++
 rtl/mdom_wvb_capture_pretrig_delay.sv | 35 +++
 rtl/mdom_wvb_capture.sv | 181 ++++++++++++++++++
 tb/tb_mdom_wvb_capture.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdom_wvb_capture_pkg.sv
// Shared constants for the waveform capture path: trigger source codes,
// waveform-buffer word layout and header field layout.
package mdom_wvb_capture_pkg;

    // Trigger source codes carried in the header
    localparam logic [1:0] TRIG_SRC_THRESH = 2'd0;
    localparam logic [1:0] TRIG_SRC_DISCR  = 2'd1;
    localparam logic [1:0] TRIG_SRC_EXT    = 2'd2;
    localparam logic [1:0] TRIG_SRC_SOFT   = 2'd3;

    // Sample word layout: {sof, eoe, adc[11:0], discr[7:0]}
    localparam int ADC_W         = 12;
    localparam int DISCR_W       = 8;
    localparam int SAMP_W        = ADC_W + DISCR_W;
    localparam int WVB_W         = SAMP_W + 2;
    localparam int WVB_SOF_BIT   = 21;
    localparam int WVB_EOE_BIT   = 20;
    localparam int WVB_ADC_LSB   = 8;
    localparam int WVB_DISCR_LSB = 0;

    // Header layout: {trig_src[1:0], ltc[47:0], length[12:0]}
    localparam int LTC_W       = 48;
    localparam int LEN_W       = 13;
    localparam int HDR_W       = 63;
    localparam int HDR_SRC_LSB = 61;
    localparam int HDR_LTC_LSB = 13;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } cap_state_t;

    function automatic logic [HDR_W-1:0] pack_hdr(input logic [1:0]       src,
                                                   input logic [LTC_W-1:0] ltc_v,
                                                   input logic [LEN_W-1:0] len);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_SRC_LSB +: 2]     = src;
        h[HDR_LTC_LSB +: LTC_W] = ltc_v;
        h[HDR_LEN_LSB +: LEN_W] = len;
        return h;
    endfunction

    // Delay-line samples are stored as {adc, discr}
    function automatic logic [WVB_W-1:0] pack_wvb(input logic              sof,
                                                   input logic              eoe,
                                                   input logic [SAMP_W-1:0] s);
        logic [WVB_W-1:0] w;
        w = '0;
        w[WVB_SOF_BIT]               = sof;
        w[WVB_EOE_BIT]               = eoe;
        w[WVB_ADC_LSB +: ADC_W]      = s[DISCR_W +: ADC_W];
        w[WVB_DISCR_LSB +: DISCR_W]  = s[0 +: DISCR_W];
        return w;
    endfunction

endpackage

// File: rtl/mdom_wvb_capture_pretrig_delay.sv
// Pre-trigger delay line: DEPTH-deep shift register (the live input counts
// as tap 0) with a registered variable tap. tap holds the input from
// sel cycles before the edge that loaded it.
module pretrig_delay #(
    parameter int W     = 20,
    parameter int DEPTH = 32,
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     tap
);

    logic [DEPTH-1:1][W-1:0] sr;
    logic [DEPTH-1:0][W-1:0] line;

    // Tap 0 is the live input, tap i is the input from i cycles ago
    always_comb begin
        line = {sr, din};
    end

    // Shift every cycle; reset wipes history so stale samples never leak out
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            tap <= '0;
        end else begin
            sr  <= line[DEPTH-2:0];
            tap <= line[sel];
        end
    end

endmodule

// File: rtl/mdom_wvb_capture.sv
// Waveform capture controller: on an accepted trigger writes pre-trigger,
// trigger and post-trigger samples (optionally extended by time-over-threshold)
// into the waveform buffer, then one header word with src/ltc/length.
module mdom_wvb_capture
    import mdom_wvb_capture_pkg::*;
#(
    parameter int PRE_MAX = 31,
    parameter int MAX_LEN = 4096,
    localparam int PRE_W  = $clog2(PRE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       adc_stream_in,
    input  logic [7:0]        discr_stream_in,
    input  logic              trig,
    input  logic [1:0]        trig_src,
    input  logic              thresh_tot,
    input  logic              discr_tot,
    input  logic [47:0]       ltc,
    input  logic              arm,
    input  logic [PRE_W-1:0]  pre_conf,
    input  logic [11:0]       post_conf,
    input  logic              extend,
    input  logic              wvb_full,
    output logic              wvb_wr_en,
    output logic [21:0]       wvb_wr_data,
    output logic              hdr_wr_en,
    output logic [62:0]       hdr_data,
    output logic              overflow,
    output logic              busy
);

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

    logic              rst_q;
    cap_state_t        state;

    // Event parameters frozen at trigger acceptance
    logic [1:0]        src_lat;
    logic [LTC_W-1:0]  ltc_lat;
    logic [PRE_W-1:0]  pre_lat;
    logic [11:0]       post_lat;
    logic              ext_lat;

    // k_q: index of the last sample written; end_k: index that will carry eoe
    logic [LEN_W-1:0]  k_q;
    logic [LEN_W-1:0]  end_k;
    logic              end_vld;
    logic              done_q;
    logic              sof_q;
    logic              eoe_q;
    logic [SAMP_W-1:0] tap;

    logic              accept;
    logic              drop;
    logic              writing;
    logic              tot;
    logic              found_now;
    logic              last;
    logic [PRE_W-1:0]  pre_cur;
    logic [11:0]       post_cur;
    logic              ext_cur;
    logic [1:0]        src_cur;
    logic [LTC_W-1:0]  ltc_cur;
    logic [LEN_W-1:0]  k_cur;
    logic [LEN_W-1:0]  end_k_cur;

    // Reset is registered once before it touches any state
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Write-side decode. Sample k is loaded at the edge ending cycle T+k, at
    // which point the live input is S_{T+k}; the written sample is S_{T+k-pre}.
    // So the end of an extended event is found on the live input and eoe
    // lands pre writes later.
    always_comb begin
        accept    = (state == S_IDLE) && trig && arm && !wvb_full;
        drop      = (state == S_IDLE) && trig && arm && wvb_full;
        writing   = accept || ((state == S_CAPTURE) && !done_q);
        tot       = thresh_tot | discr_tot;
        pre_cur   = (state == S_IDLE) ? pre_conf  : pre_lat;
        post_cur  = (state == S_IDLE) ? post_conf : post_lat;
        ext_cur   = (state == S_IDLE) ? extend    : ext_lat;
        src_cur   = (state == S_IDLE) ? trig_src  : src_lat;
        ltc_cur   = (state == S_IDLE) ? ltc       : ltc_lat;
        k_cur     = accept ? '0 : (k_q + LEN_W'(1));
        found_now = !end_vld && (k_cur >= LEN_W'(post_cur)) && (!ext_cur || !tot);
        end_k_cur = end_vld ? end_k : (k_cur + LEN_W'(pre_cur));
        last      = ((end_vld || found_now) && (k_cur == end_k_cur)) ||
                    (k_cur == LAST_IDX);
    end

    pretrig_delay #(
        .W     (SAMP_W),
        .DEPTH (PRE_MAX + 1)
    ) u_delay (
        .clk (clk),
        .rst (rst_q),
        .din ({adc_stream_in, discr_stream_in}),
        .sel (pre_cur),
        .tap (tap)
    );

    assign wvb_wr_data = wvb_wr_en ? pack_wvb(sof_q, eoe_q, tap) : '0;

    // Capture FSM with registered strobes; CAPTURE keeps one tail cycle after
    // the eoe write so a trigger coincident with eoe is still ignored.
    always_ff @(posedge clk) begin
        if (rst_q) begin
            state     <= S_IDLE;
            src_lat   <= '0;
            ltc_lat   <= '0;
            pre_lat   <= '0;
            post_lat  <= '0;
            ext_lat   <= 1'b0;
            k_q       <= '0;
            end_k     <= '0;
            end_vld   <= 1'b0;
            done_q    <= 1'b0;
            sof_q     <= 1'b0;
            eoe_q     <= 1'b0;
            wvb_wr_en <= 1'b0;
            hdr_wr_en <= 1'b0;
            hdr_data  <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wvb_wr_en <= 1'b0;
            sof_q     <= 1'b0;
            eoe_q     <= 1'b0;
            hdr_wr_en <= 1'b0;
            hdr_data  <= '0;
            overflow  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_CAPTURE;
                        busy     <= 1'b1;
                        src_lat  <= trig_src;
                        ltc_lat  <= ltc;
                        pre_lat  <= pre_conf;
                        post_lat <= post_conf;
                        ext_lat  <= extend;
                        end_vld  <= 1'b0;
                        done_q   <= 1'b0;
                    end else if (drop) begin
                        overflow <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (done_q) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done_q  <= 1'b0;
                        end_vld <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (writing) begin
                wvb_wr_en <= 1'b1;
                sof_q     <= (k_cur == '0);
                eoe_q     <= last;
                k_q       <= k_cur;
                if (found_now) begin
                    end_vld <= 1'b1;
                    end_k   <= end_k_cur;
                end
                if (last) begin
                    done_q    <= 1'b1;
                    hdr_wr_en <= 1'b1;
                    hdr_data  <= pack_hdr(src_cur, ltc_cur, k_cur + LEN_W'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_mdom_wvb_capture.sv
// Directed bench for mdom_wvb_capture. ADC input is a ramp equal to the
// cycle number, so every written sample identifies its source cycle.
module tb_mdom_wvb_capture;
    import mdom_wvb_capture_pkg::*;

    localparam logic [47:0] LTC_BASE = 48'h0123_4567_0000;

    logic        clk;
    logic        rst;
    logic [11:0] adc_stream_in;
    logic [7:0]  discr_stream_in;
    logic        trig;
    logic [1:0]  trig_src;
    logic        thresh_tot;
    logic        discr_tot;
    logic [47:0] ltc;
    logic        arm;
    logic [4:0]  pre_conf;
    logic [11:0] post_conf;
    logic        extend;
    logic        wvb_full;
    logic        wvb_wr_en;
    logic [21:0] wvb_wr_data;
    logic        hdr_wr_en;
    logic [62:0] hdr_data;
    logic        overflow;
    logic        busy;

    mdom_wvb_capture #(.PRE_MAX(31), .MAX_LEN(4096)) dut (
        .clk             (clk),
        .rst             (rst),
        .adc_stream_in   (adc_stream_in),
        .discr_stream_in (discr_stream_in),
        .trig            (trig),
        .trig_src        (trig_src),
        .thresh_tot      (thresh_tot),
        .discr_tot       (discr_tot),
        .ltc             (ltc),
        .arm             (arm),
        .pre_conf        (pre_conf),
        .post_conf       (post_conf),
        .extend          (extend),
        .wvb_full        (wvb_full),
        .wvb_wr_en       (wvb_wr_en),
        .wvb_wr_data     (wvb_wr_data),
        .hdr_wr_en       (hdr_wr_en),
        .hdr_data        (hdr_data),
        .overflow        (overflow),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge
    int          wq_c[$];
    logic [21:0] wq_d[$];
    int          hq_c[$];
    logic [62:0] hq_d[$];
    int          oq_c[$];
    int          bq_c[$];

    always @(negedge clk) begin
        if (wvb_wr_en) begin wq_c.push_back(cyc); wq_d.push_back(wvb_wr_data); end
        if (hdr_wr_en) begin hq_c.push_back(cyc); hq_d.push_back(hdr_data); end
        if (overflow)  oq_c.push_back(cyc);
        if (busy)      bq_c.push_back(cyc);
    end

    int checks = 0;
    int failures = 0;
    int w0, h0, o0, b0;
    int thr_lo = 1, thr_hi = 0;
    int dsc_lo = 1, dsc_hi = 0;
    int T, T2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] samp(input int c, input logic s, input logic e);
        logic [31:0] v;
        v = c;
        return {s, e, v[11:0], v[7:0] ^ 8'h5A};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            adc_stream_in   = cyc[11:0];
            discr_stream_in = cyc[7:0] ^ 8'h5A;
            ltc             = LTC_BASE + 48'(cyc);
            trig            = 1'b0;
            thresh_tot      = (cyc >= thr_lo) && (cyc <= thr_hi);
            discr_tot       = (cyc >= dsc_lo) && (cyc <= dsc_hi);
        end
    endtask

    task automatic fire(input logic [1:0] src);
        step(1);
        trig     = 1'b1;
        trig_src = src;
    endtask

    task automatic mark();
        w0 = wq_c.size(); h0 = hq_c.size(); o0 = oq_c.size(); b0 = bq_c.size();
    endtask

    // n writes starting at log offset wi, trigger at t, pre samples pre
    task automatic check_writes(input string tag, input int wi, input int t, input int pre,
                                input int n, input logic eoe_last);
        for (int k = 0; k < n; k++) begin
            if (w0 + wi + k < wq_c.size()) begin
                chk($sformatf("%s.cyc%0d", tag, k), 64'(wq_c[w0+wi+k]), 64'(t + 1 + k));
                chk($sformatf("%s.dat%0d", tag, k), 64'(wq_d[w0+wi+k]),
                    64'(samp(t - pre + k, k == 0, eoe_last && (k == n - 1))));
            end
        end
    endtask

    task automatic check_hdr(input string tag, input int hi, input int t, input int n,
                             input logic [1:0] src);
        if (h0 + hi < hq_c.size()) begin
            chk({tag, ".hcyc"}, 64'(hq_c[h0+hi]), 64'(t + n));
            chk({tag, ".hdr"}, 64'(hq_d[h0+hi]), 64'({src, LTC_BASE + 48'(t), 13'(n)}));
        end
    endtask

    task automatic check_busy(input string tag, input int t, input int n);
        chk({tag, ".nbusy"}, 64'(bq_c.size() - b0), 64'(n));
        if (bq_c.size() > b0) begin
            chk({tag, ".busy_first"}, 64'(bq_c[b0]), 64'(t + 1));
            chk({tag, ".busy_last"}, 64'(bq_c[bq_c.size()-1]), 64'(t + n));
        end
    endtask

    task automatic check_single(input string tag, input int t, input int pre, input int n,
                                input logic [1:0] src);
        chk({tag, ".nwr"}, 64'(wq_c.size() - w0), 64'(n));
        chk({tag, ".nhdr"}, 64'(hq_c.size() - h0), 64'd1);
        chk({tag, ".novf"}, 64'(oq_c.size() - o0), 64'd0);
        check_writes(tag, 0, t, pre, n, 1'b1);
        check_hdr(tag, 0, t, n, src);
        check_busy(tag, t, n);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, ".wr_en"}, 64'(wvb_wr_en), 64'd0);
        chk({tag, ".wr_data"}, 64'(wvb_wr_data), 64'd0);
        chk({tag, ".hdr_en"}, 64'(hdr_wr_en), 64'd0);
        chk({tag, ".hdr_data"}, 64'(hdr_data), 64'd0);
        chk({tag, ".ovf"}, 64'(overflow), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; trig_src = TRIG_SRC_THRESH;
        adc_stream_in = '0; discr_stream_in = '0; ltc = '0;
        thresh_tot = 1'b0; discr_tot = 1'b0; arm = 1'b1;
        pre_conf = 5'd0; post_conf = 12'd0; extend = 1'b0; wvb_full = 1'b0;

        // Reset state
        step(5);
        rst = 1'b0;
        step(3);
        check_outputs_zero("reset");

        // Basic event: pre=3 post=4, trigger sample adc=100; config changed afterwards
        while (cyc < 99) step(1);
        mark();
        fire(TRIG_SRC_EXT);
        T = cyc; pre_conf = 5'd3; post_conf = 12'd4; extend = 1'b0;
        step(1);
        pre_conf = 5'd9; post_conf = 12'd50; trig_src = TRIG_SRC_SOFT; extend = 1'b1;
        step(15);
        chk("basic.first_adc", 64'(T - 3), 64'd97);
        check_single("basic", T, 3, 8, TRIG_SRC_EXT);

        // pre=0 post=0: single sof+eoe write of the trigger sample
        extend = 1'b0;
        mark();
        fire(TRIG_SRC_DISCR);
        T = cyc; pre_conf = 5'd0; post_conf = 12'd0;
        step(8);
        check_single("p0", T, 0, 1, TRIG_SRC_DISCR);

        // Extend by thresh_tot high for 10 cycles from T: length 13
        mark();
        fire(TRIG_SRC_THRESH);
        T = cyc; pre_conf = 5'd2; post_conf = 12'd5; extend = 1'b1;
        thr_lo = T; thr_hi = T + 9; thresh_tot = 1'b1;
        step(20);
        check_single("ext", T, 2, 13, TRIG_SRC_THRESH);

        // Same tot with extend=0: base length 8
        mark();
        fire(TRIG_SRC_THRESH);
        T = cyc; extend = 1'b0;
        thr_lo = T; thr_hi = T + 9; thresh_tot = 1'b1;
        step(20);
        check_single("noext", T, 2, 8, TRIG_SRC_THRESH);
        thr_lo = 1; thr_hi = 0;

        // Extend via discr_tot high T+3..T+6: ends at live sample T+7, length 10
        mark();
        fire(TRIG_SRC_DISCR);
        T = cyc; extend = 1'b1;
        dsc_lo = T + 3; dsc_hi = T + 6;
        step(20);
        check_single("ext_discr", T, 2, 10, TRIG_SRC_DISCR);
        dsc_lo = 1; dsc_hi = 0; extend = 1'b0;

        // Dropped trigger while buffer full: one overflow pulse, nothing written
        mark();
        wvb_full = 1'b1;
        fire(TRIG_SRC_EXT);
        T = cyc;
        step(10);
        chk("full.novf", 64'(oq_c.size() - o0), 64'd1);
        if (oq_c.size() > o0) chk("full.ovf_cyc", 64'(oq_c[o0]), 64'(T + 1));
        chk("full.nwr", 64'(wq_c.size() - w0), 64'd0);
        chk("full.nhdr", 64'(hq_c.size() - h0), 64'd0);
        chk("full.nbusy", 64'(bq_c.size() - b0), 64'd0);

        // Disarmed trigger: silently ignored
        mark();
        wvb_full = 1'b0; arm = 1'b0;
        fire(TRIG_SRC_EXT);
        step(10);
        chk("disarm.novf", 64'(oq_c.size() - o0), 64'd0);
        chk("disarm.nwr", 64'(wq_c.size() - w0), 64'd0);
        arm = 1'b1;

        // Retrigger boundary, L=4: trig in CAPTURE (full, disarmed) and at T+L
        // ignored; trig at T+L+1 starts a new event
        mark();
        fire(TRIG_SRC_SOFT);
        T = cyc; pre_conf = 5'd1; post_conf = 12'd2;
        step(2);
        trig = 1'b1; wvb_full = 1'b1; arm = 1'b0;
        step(1);
        wvb_full = 1'b0; arm = 1'b1;
        step(1);
        trig = 1'b1; trig_src = TRIG_SRC_DISCR;
        step(1);
        T2 = cyc; trig = 1'b1; trig_src = TRIG_SRC_THRESH;
        step(12);
        chk("retrig.t2", 64'(T2), 64'(T + 5));
        chk("retrig.nwr", 64'(wq_c.size() - w0), 64'd8);
        chk("retrig.nhdr", 64'(hq_c.size() - h0), 64'd2);
        chk("retrig.novf", 64'(oq_c.size() - o0), 64'd0);
        check_writes("retrig.a", 0, T, 1, 4, 1'b1);
        check_writes("retrig.b", 4, T2, 1, 4, 1'b1);
        check_hdr("retrig.a", 0, T, 4, TRIG_SRC_SOFT);
        check_hdr("retrig.b", 1, T2, 4, TRIG_SRC_THRESH);

        // Reset during capture at k=3: abort, then a new event sees a cleared line
        mark();
        fire(TRIG_SRC_EXT);
        T = cyc; pre_conf = 5'd3; post_conf = 12'd20;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        check_outputs_zero("rstmid");
        step(1);
        chk("rstmid.nwr", 64'(wq_c.size() - w0), 64'd5);
        chk("rstmid.nhdr", 64'(hq_c.size() - h0), 64'd0);
        check_writes("rstmid", 0, T, 3, 5, 1'b0);
        mark();
        fire(TRIG_SRC_SOFT);
        T2 = cyc; pre_conf = 5'd5; post_conf = 12'd0;
        step(12);
        chk("postrst.t2", 64'(T2), 64'(T + 8));
        chk("postrst.nwr", 64'(wq_c.size() - w0), 64'd6);
        if (wq_c.size() >= w0 + 6) begin
            chk("postrst.dat0", 64'(wq_d[w0]),   64'({1'b1, 1'b0, 20'd0}));
            chk("postrst.dat1", 64'(wq_d[w0+1]), 64'({1'b1, 1'b0, 20'd0} ^ {1'b1, 21'd0}));
            chk("postrst.dat2", 64'(wq_d[w0+2]), 64'd0);
            chk("postrst.dat3", 64'(wq_d[w0+3]), 64'(samp(T + 6, 1'b0, 1'b0)));
            chk("postrst.dat4", 64'(wq_d[w0+4]), 64'(samp(T + 7, 1'b0, 1'b0)));
            chk("postrst.dat5", 64'(wq_d[w0+5]), 64'(samp(T + 8, 1'b0, 1'b1)));
            chk("postrst.cyc0", 64'(wq_c[w0]), 64'(T2 + 1));
        end
        check_hdr("postrst", 0, T2, 6, TRIG_SRC_SOFT);

        // Length cap: tot held high forever with extend -> eoe forced at 4096
        mark();
        fire(TRIG_SRC_EXT);
        T = cyc; pre_conf = 5'd0; post_conf = 12'd0; extend = 1'b1;
        thr_lo = T; thr_hi = T + 5000; thresh_tot = 1'b1;
        step(4105);
        check_single("cap", T, 0, 4096, TRIG_SRC_EXT);
        thr_lo = 1; thr_hi = 0; extend = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
